next_state_generator: RTL and testbench

- Combinational next-state and counter-control decoder for the Bound Flasher, a 16-lamp sequencer.
- Takes the current main FSM state (from the external state register) and the external lit-lamp counter.
- Produces the next state, the counter direction command, and a synchronous counter load.
- Contains one internal flop: a kickback edge detector, so each kickback request is accepted exactly once.

---
 rtl/bf_pkg.sv | 26 ++
 rtl/next_state_generator.sv | 115 +++++++++++
 tb/tb_next_state_generator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared types and thresholds for the Bound Flasher lamp sequencer.
package bf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP_0_15 = 3'd1,
        ST_DN_15_5 = 3'd2,
        ST_UP_5_10 = 3'd3,
        ST_DN_10_0 = 3'd4,
        ST_UP_0_5  = 3'd5,
        ST_DN_5_0  = 3'd6,
        ST_ILLEGAL = 3'd7
    } main_state_e;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_UP   = 2'b01,
        CNT_DOWN = 2'b10
    } count_state_e;

    localparam logic [4:0] LAMP_MAX = 5'd16;
    localparam logic [4:0] KB_HI    = 5'd11;
    localparam logic [4:0] KB_LO    = 5'd5;
    localparam logic [4:0] MID_HI   = 5'd6;

endpackage

// File: rtl/next_state_generator.sv
// Next-state / counter-command decoder for the Bound Flasher main FSM.
// Holds only the kickback edge-detect flop; state and counter live outside.
module next_state_generator
    import bf_pkg::*;
#(
    parameter int LAMPS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] main_state,
    input  logic [4:0] counter,
    input  logic       flick,
    input  logic       kickback_match,
    output logic [2:0] main_state_n,
    output logic [4:0] counter_load,
    output logic       counter_load_en,
    output logic [1:0] count_state
);

    localparam logic [4:0] L_TOP = 5'(LAMPS);

    logic         r_kb_q;
    logic         w_kb_acc;
    main_state_e  w_state;
    main_state_e  w_next;
    count_state_e w_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_kb_q <= 1'b0;
        else     r_kb_q <= kickback_match;
    end

    // Only a rising edge is accepted, so a held request cannot re-trigger.
    assign w_kb_acc = kickback_match & ~r_kb_q;
    assign w_state  = main_state_e'(main_state);

    always_comb begin
        w_next          = w_state;
        w_cmd           = CNT_HOLD;
        counter_load    = '0;
        counter_load_en = 1'b0;
        case (w_state)
            ST_IDLE: begin
                if (flick) begin
                    w_next = ST_UP_0_15;
                    w_cmd  = CNT_UP;
                end else begin
                    counter_load_en = 1'b1;
                end
            end
            ST_UP_0_15: begin
                if (counter >= L_TOP) begin
                    w_next = ST_DN_15_5;
                    w_cmd  = CNT_DOWN;
                end else begin
                    w_cmd  = CNT_UP;
                end
            end
            ST_DN_15_5: begin
                if (counter <= KB_LO) begin
                    w_next = ST_UP_5_10;
                    w_cmd  = CNT_UP;
                end else begin
                    w_cmd  = CNT_DOWN;
                end
            end
            ST_UP_5_10: begin
                if (w_kb_acc) begin
                    w_next = ST_DN_15_5;
                    w_cmd  = CNT_DOWN;
                end else if (counter >= KB_HI) begin
                    w_next = ST_DN_10_0;
                    w_cmd  = CNT_DOWN;
                end else begin
                    w_cmd  = CNT_UP;
                end
            end
            ST_DN_10_0: begin
                if (counter == '0) begin
                    w_next = ST_UP_0_5;
                    w_cmd  = CNT_UP;
                end else begin
                    w_cmd  = CNT_DOWN;
                end
            end
            ST_UP_0_5: begin
                if (w_kb_acc) begin
                    w_next = ST_DN_10_0;
                    w_cmd  = CNT_DOWN;
                end else if (counter >= MID_HI) begin
                    w_next = ST_DN_5_0;
                    w_cmd  = CNT_DOWN;
                end else begin
                    w_cmd  = CNT_UP;
                end
            end
            ST_DN_5_0: begin
                if (counter == '0) begin
                    w_next          = ST_IDLE;
                    counter_load_en = 1'b1;
                end else begin
                    w_cmd  = CNT_DOWN;
                end
            end
            default: begin
                w_next          = ST_IDLE;
                counter_load_en = 1'b1;
            end
        endcase
    end

    assign main_state_n = w_next;
    assign count_state  = w_cmd;

endmodule

// File: tb/tb_next_state_generator.sv
// Scoreboard bench for next_state_generator: directed cases then random vectors.
module tb_next_state_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] main_state = '0;
    logic [4:0] counter = '0;
    logic       flick = 1'b0;
    logic       kickback_match = 1'b0;
    logic [2:0] main_state_n;
    logic [4:0] counter_load;
    logic       counter_load_en;
    logic [1:0] count_state;

    next_state_generator #(.LAMPS(16)) dut (
        .clk(clk), .rst(rst), .main_state(main_state), .counter(counter),
        .flick(flick), .kickback_match(kickback_match),
        .main_state_n(main_state_n), .counter_load(counter_load),
        .counter_load_en(counter_load_en), .count_state(count_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [2:0] ns;
        logic [1:0] cs;
        logic       en;
        logic [4:0] ld;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_id = 0;

    // Rule tables per state: 0 idle, 1 counting up, 2 counting down, 3 illegal.
    int kind[8]     = '{0, 1, 2, 1, 2, 1, 2, 3};
    int up_limit[8] = '{0, 16, 0, 11, 0, 6, 0, 0};
    int up_exit[8]  = '{0, 2, 0, 4, 0, 6, 0, 0};
    int kb_dest[8]  = '{-1, -1, -1, 2, -1, 4, -1, -1};
    int dn_floor[8] = '{0, 0, 5, 0, 0, 0, 0, 0};
    int dn_exit[8]  = '{0, 0, 3, 0, 5, 0, 0, 0};

    logic m_kb_old  = 1'b0;
    logic m_rst_old = 1'b1;

    function automatic exp_t model(int s, int c, bit f, bit k, bit kbq);
        exp_t e;
        bit   acc = k && !kbq;
        e.id = 0; e.ns = 3'(s); e.cs = 2'd0; e.en = 1'b0; e.ld = 5'd0;
        case (kind[s])
            0: if (f) begin e.ns = 3'd1; e.cs = 2'd1; end
               else e.en = 1'b1;
            1: if (acc && kb_dest[s] >= 0) begin e.ns = 3'(kb_dest[s]); e.cs = 2'd2; end
               else if (c >= up_limit[s]) begin e.ns = 3'(up_exit[s]); e.cs = 2'd2; end
               else e.cs = 2'd1;
            2: if (c <= dn_floor[s]) begin
                   e.ns = 3'(dn_exit[s]);
                   if (dn_exit[s] == 0) e.en = 1'b1;
                   else e.cs = 2'd1;
               end else e.cs = 2'd2;
            default: begin e.ns = 3'd0; e.en = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic apply(input bit r, input int s, input int c, input bit f, input bit k);
        exp_t e;
        bit   kbq;
        @(posedge clk);
        kbq = m_rst_old ? 1'b0 : m_kb_old;
        #1;
        rst = r; main_state = 3'(s); counter = 5'(c); flick = f; kickback_match = k;
        m_rst_old = r; m_kb_old = k;
        e = model(s, c, f, k, r ? 1'b0 : kbq);
        e.id = vec_id++;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (main_state_n !== e.ns) begin
                    errors++;
                    $display("FAIL ns vec=%0d state=%0d cnt=%0d got=%0d exp=%0d",
                             e.id, main_state, counter, main_state_n, e.ns);
                end
                checks++;
                if (count_state !== e.cs) begin
                    errors++;
                    $display("FAIL count_state vec=%0d state=%0d cnt=%0d got=%b exp=%b",
                             e.id, main_state, counter, count_state, e.cs);
                end
                checks++;
                if (counter_load_en !== e.en) begin
                    errors++;
                    $display("FAIL load_en vec=%0d state=%0d got=%b exp=%b",
                             e.id, main_state, counter_load_en, e.en);
                end
                checks++;
                if (counter_load !== e.ld) begin
                    errors++;
                    $display("FAIL load vec=%0d got=%0d exp=%0d", e.id, counter_load, e.ld);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 1, 15, 0, 0);
        apply(0, 1, 16, 0, 0);
        apply(0, 2, 5, 0, 0);
        apply(0, 2, 6, 0, 0);
        apply(0, 3, 8, 0, 0);
        apply(0, 3, 8, 0, 1);
        apply(0, 3, 8, 0, 1);
        apply(0, 3, 11, 0, 1);
        apply(0, 5, 3, 0, 0);
        apply(0, 5, 3, 0, 1);
        apply(0, 5, 6, 0, 0);
        apply(0, 4, 0, 0, 1);
        apply(0, 6, 1, 0, 0);
        apply(0, 6, 0, 0, 0);
        apply(0, 7, 9, 1, 1);
        apply(0, 1, 20, 0, 0);
        apply(0, 4, 20, 0, 0);
        apply(1, 3, 8, 0, 1);
        apply(1, 3, 8, 0, 1);
        apply(0, 3, 8, 0, 1);
        apply(0, 3, 8, 0, 1);
        for (int i = 0; i < 400; i++) begin
            int c;
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, 16));
            apply($urandom_range(0, 40) == 0, int'($urandom_range(0, 7)), c,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        end
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
